// File: rtl/nes_pad_uart_tx_if.sv
// Pad and UART signal bundle for nes_pad_uart_tx.
interface nes_pad_uart_tx_if;
    logic       pad_data;
    logic       pad_latch;
    logic       pad_clk;
    logic       txd;
    logic [7:0] buttons;
    logic       tx_busy;
    logic       frame_sent;

    // Adapter side: samples the pad, drives latch/clock and the UART line
    modport master (
        input  pad_data,
        output pad_latch,
        output pad_clk,
        output txd,
        output buttons,
        output tx_busy,
        output frame_sent
    );

    // Environment side: the gamepad and the UART receiver
    modport slave (
        output pad_data,
        input  pad_latch,
        input  pad_clk,
        input  txd,
        input  buttons,
        input  tx_busy,
        input  frame_sent
    );
endinterface

// File: rtl/nes_pad_uart_tx.sv
// nes_pad_uart_tx: periodically reads an NES gamepad through its latch/clock/data
// shift register and sends the button byte as one 8N1 UART frame on txd.
// Optional feature macro: PAD_TX_ON_CHANGE_EN -- when defined, a read whose byte
// equals the last transmitted byte sends no frame.
module nes_pad_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned PAD_HALF     = 300,
    parameter int unsigned POLL_DIV     = 833333
) (
    input  logic              clk,
    input  logic              rst,
    nes_pad_uart_tx_if.master bus
);

    localparam int unsigned LATCH_CYC = 2 * PAD_HALF;
    localparam int unsigned CNT_MAX   = (LATCH_CYC > CLKS_PER_BIT) ? LATCH_CYC : CLKS_PER_BIT;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned POLL_W    = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

    localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(LATCH_CYC - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(PAD_HALF - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    // Only meaningful when CLKS_PER_BIT >= 2; every use is guarded
    localparam logic [CNT_W-1:0]  BIT_PENULT = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SETTLE,
        S_CLK_HI,
        S_CLK_LO,
        S_TX_START,
        S_TX_DATA,
        S_TX_STOP
    } state_e;

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [2:0]         bit_q,     bit_d;
    logic [7:0]         data_q,    data_d;
    logic [7:0]         buttons_q, buttons_d;
    logic [7:0]         last_q,    last_d;
    logic [POLL_W-1:0]  poll_q,    poll_d;
    logic               pend_q,    pend_d;
    logic               latch_q,   latch_d;
    logic               pclk_q,    pclk_d;
    logic               txd_q,     txd_d;
    logic               busy_q,    busy_d;
    logic               sent_q,    sent_d;

    logic [7:0]         sample;
    logic               tx_go;

    assign bus.pad_latch  = latch_q;
    assign bus.pad_clk    = pclk_q;
    assign bus.txd        = txd_q;
    assign bus.buttons    = buttons_q;
    assign bus.tx_busy    = busy_q;
    assign bus.frame_sent = sent_q;

    // Next-state, next-output and poll-timer logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_d     = bit_q;
        data_d    = data_q;
        buttons_d = buttons_q;
        last_d    = last_q;
        pend_d    = pend_q;
        latch_d   = 1'b0;
        pclk_d    = 1'b0;
        txd_d     = 1'b1;
        busy_d    = 1'b0;
        sent_d    = 1'b0;
        tx_go     = 1'b0;
        // Pad bits are active-low and arrive A first, so shift in from the top
        sample    = {~bus.pad_data, data_q[7:1]};

        if (pend_q && state_q == S_IDLE) begin
            pend_d = 1'b0;
        end

        // Free-running poll timer; a wrap while a request is pending is absorbed
        if (poll_q == POLL_LAST) begin
            poll_d = '0;
            pend_d = 1'b1;
        end else begin
            poll_d = poll_q + POLL_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (pend_q) begin
                    state_d = S_LATCH;
                    latch_d = 1'b1;
                end
            end

            S_LATCH: begin
                latch_d = 1'b1;
                if (cnt_q == LATCH_LAST) begin
                    latch_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (cnt_q == HALF_LAST) begin
                    data_d  = sample;
                    bit_d   = 3'd0;
                    cnt_d   = '0;
                    pclk_d  = 1'b1;
                    state_d = S_CLK_HI;
                end
            end

            S_CLK_HI: begin
                pclk_d = 1'b1;
                if (cnt_q == HALF_LAST) begin
                    pclk_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_CLK_LO;
                end
            end

            S_CLK_LO: begin
                if (cnt_q == HALF_LAST) begin
                    data_d = sample;
                    cnt_d  = '0;
                    if (bit_q == 3'd6) begin
                        // All eight bits present: publish and decide on a frame
                        buttons_d = sample;
`ifdef PAD_TX_ON_CHANGE_EN
                        tx_go     = (sample != last_q);
`else
                        tx_go     = 1'b1;
`endif
                        if (tx_go) begin
                            last_d  = sample;
                            bit_d   = 3'd0;
                            txd_d   = 1'b0;
                            busy_d  = 1'b1;
                            state_d = S_TX_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        pclk_d  = 1'b1;
                        state_d = S_CLK_HI;
                    end
                end
            end

            S_TX_START: begin
                busy_d = 1'b1;
                txd_d  = 1'b0;
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    txd_d   = data_q[0];
                    state_d = S_TX_DATA;
                end
            end

            S_TX_DATA: begin
                busy_d = 1'b1;
                txd_d  = data_q[0];
                if (cnt_q == BIT_LAST) begin
                    cnt_d  = '0;
                    data_d = {1'b0, data_q[7:1]};
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_TX_STOP;
                        if (CLKS_PER_BIT == 1) begin
                            sent_d = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        txd_d = data_q[1];
                    end
                end
            end

            S_TX_STOP: begin
                busy_d = 1'b1;
                txd_d  = 1'b1;
                if (CLKS_PER_BIT > 1 && cnt_q == BIT_PENULT) begin
                    sent_d = 1'b1;
                end
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            data_q    <= 8'h00;
            buttons_q <= 8'h00;
            last_q    <= 8'h00;
            poll_q    <= '0;
            pend_q    <= 1'b0;
            latch_q   <= 1'b0;
            pclk_q    <= 1'b0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            sent_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            buttons_q <= buttons_d;
            last_q    <= last_d;
            poll_q    <= poll_d;
            pend_q    <= pend_d;
            latch_q   <= latch_d;
            pclk_q    <= pclk_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            sent_q    <= sent_d;
        end
    end

endmodule
